key_expander: RTL and testbench

KEY_EXPANDER -- requirements
Module: key_expander

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/sub_word.sv | 16 +
 rtl/key_expander.sv | 121 ++++++++++++
 tb/tb_key_expander.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, rcon constants,
// FSM state type, the forward S-box and small GF(2^8) helpers.
package aes_pkg;

    localparam int         NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Forward AES S-box, entry i is SubBytes(i).
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8): shift left, reduce if the old MSB was set.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

    // One-byte left rotate: the MSB byte moves to the LSB byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Purely combinational.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // Four independent byte substitutions.
    always_comb begin
        word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                    sbox(word_in[15:8]),  sbox(word_in[7:0])};
    end

endmodule

// File: rtl/key_expander.sv
// AES-128 key expander. A key_load in IDLE or DONE stores the cipher key in
// slot 0, then one round key per clock is derived into slots 1..10. All 11
// round keys remain readable through a combinational rd_idx/rd_key port.
module key_expander
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         key_ready,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam int         NUM_SLOTS  = NUM_ROUNDS + 1;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t         state;
    state_t         next_state;
    logic [3:0]     round_cnt;
    logic [7:0]     rcon;
    logic [127:0]   key_store [NUM_SLOTS];

    logic           load_accept;
    logic [127:0]   prev_key;
    logic [127:0]   next_key;
    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    n0, n1, n2, n3;
    logic [31:0]    sub_out;

    // A load is honoured only outside EXPAND; mid-expansion requests are dropped.
    assign load_accept = key_load && (state != EXPAND);

    assign busy      = (state == EXPAND);
    assign key_ready = (state == DONE);

    // State register.
    // NOTE: every clocked block uses <= so all registers sample the
    // pre-edge values of one another, independent of block ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic: IDLE/DONE -> EXPAND on load, EXPAND -> DONE after slot 10.
    // NOTE: next_state gets its default before the case so no path through
    // this block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (key_load) next_state = EXPAND;
            EXPAND:  if (round_cnt == LAST_ROUND) next_state = DONE;
            DONE:    if (key_load) next_state = EXPAND;
            default: next_state = IDLE;
        endcase
    end

    // Round counter and rcon: restart on load, advance once per slot write.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            round_cnt <= 4'd0;
            rcon      <= RCON_INIT;
        end else if (load_accept) begin
            round_cnt <= 4'd1;
            rcon      <= RCON_INIT;
        end else if (state == EXPAND) begin
            round_cnt <= round_cnt + 4'd1;
            rcon      <= xtime(rcon);
        end
    end

    // Source for the next round key: the slot written on the previous edge.
    always_comb begin
        prev_key = '0;
        if (round_cnt != 4'd0 && round_cnt <= LAST_ROUND) begin
            prev_key = key_store[round_cnt - 4'd1];
        end
    end

    assign w0 = prev_key[127:96];
    assign w1 = prev_key[95:64];
    assign w2 = prev_key[63:32];
    assign w3 = prev_key[31:0];

    sub_word u_sub_word (
        .word_in  (rot_word(w3)),
        .word_out (sub_out)
    );

    // Chained word XORs of one AES-128 key-schedule round.
    always_comb begin
        n0       = w0 ^ sub_out ^ {rcon, 24'h0};
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Round-key store: slot 0 on load, slot round_cnt during EXPAND.
    // NOTE: the store is cleared by reset on purpose, so nothing from a
    // previous key can be read back after reset; this costs a reset net on
    // every bit and keeps the store out of plain RAM macros.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) key_store[i] <= '0;
        end else if (load_accept) begin
            key_store[0] <= key_in;
        end else if (state == EXPAND) begin
            key_store[round_cnt] <= next_key;
        end
    end

    // Combinational read port; indices beyond slot 10 read as zero.
    always_comb begin
        rd_key = '0;
        if (rd_idx <= LAST_ROUND) rd_key = key_store[rd_idx];
    end

endmodule

// File: tb/tb_key_expander.sv
// Self-checking bench for key_expander: FIPS-197 vectors, load-during-expand,
// re-key from DONE, mid-expansion reset and all-zero/all-ones keys against
// an independent reference model (S-box derived from the GF(2^8) inverse).
module tb_key_expander;

    logic         clk;
    logic         n_rst;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         key_ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int passed = 0;
    int total  = 0;

    logic [7:0]   ref_sbox [256];
    logic [127:0] ref_keys [11];

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] exp;
        string        name;
    } rd_vec_t;

    rd_vec_t a1_vecs [5];

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] A1_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

    key_expander dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .key_in    (key_in),
        .key_load  (key_load),
        .busy      (busy),
        .key_ready (key_ready),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %032h expected %032h", name, act, exp);
        else             passed++;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                              ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_ref(input logic [127:0] key);
        logic [7:0]  rc = 8'h01;
        logic [31:0] w0, w1, w2, w3, t;
        ref_keys[0] = key;
        for (int r = 1; r <= 10; r++) begin
            {w0, w1, w2, w3} = ref_keys[r-1];
            t  = {w3[23:0], w3[31:24]};
            t  = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
            w0 = w0 ^ t ^ {rc, 24'h0};
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            ref_keys[r] = {w0, w1, w2, w3};
            rc = gmul(rc, 8'h02);
        end
    endtask

    task automatic read_slot(input logic [3:0] idx, output logic [127:0] val);
        rd_idx = idx;
        #1;
        val = rd_key;
    endtask

    task automatic check_all_slots(input logic [127:0] key, input string tag);
        logic [127:0] v;
        build_ref(key);
        for (int i = 0; i <= 10; i++) begin
            read_slot(4'(i), v);
            check($sformatf("%s_slot%0d", tag, i), v, ref_keys[i]);
        end
    endtask

    // Caller is at a falling edge; key_load is sampled at the next rising edge.
    task automatic launch(input logic [127:0] key);
        key_in   = key;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Checks busy/key_ready after load edge k+c for c = 0..10; optionally
    // pulses key_load (with a different key) so it is sampled at edge k+glitch_at.
    task automatic track(input logic [127:0] key, input int glitch_at, input string tag);
        check($sformatf("%s_busy_c0", tag), {127'h0, busy}, 128'h1);
        check($sformatf("%s_ready_c0", tag), {127'h0, key_ready}, 128'h0);
        for (int c = 1; c <= 10; c++) begin
            if (c == glitch_at) begin
                key_in   = ~key;
                key_load = 1'b1;
            end
            @(negedge clk);
            key_load = 1'b0;
            key_in   = key;
            check($sformatf("%s_busy_c%0d", tag, c), {127'h0, busy}, {127'h0, c < 10});
            check($sformatf("%s_ready_c%0d", tag, c), {127'h0, key_ready}, {127'h0, c == 10});
        end
    endtask

    initial begin
        logic [127:0] v;

        n_rst    = 1'b0;
        key_load = 1'b0;
        key_in   = '0;
        rd_idx   = '0;
        build_sbox();

        a1_vecs[0] = '{4'd0,  KEY_A1, "a1_rd0"};
        a1_vecs[1] = '{4'd1,  A1_R1,  "a1_rd1"};
        a1_vecs[2] = '{4'd10, A1_R10, "a1_rd10"};
        a1_vecs[3] = '{4'd11, 128'h0, "a1_rd11_oob"};
        a1_vecs[4] = '{4'd15, 128'h0, "a1_rd15_oob"};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", {127'h0, busy}, 128'h0);
        check("rst_ready", {127'h0, key_ready}, 128'h0);
        for (int i = 0; i < 16; i++) begin
            read_slot(4'(i), v);
            check($sformatf("rst_rd%0d", i), v, 128'h0);
        end

        // FIPS-197 A.1 expansion from IDLE.
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        launch(KEY_A1);
        track(KEY_A1, 0, "a1");
        for (int i = 0; i < 5; i++) begin
            read_slot(a1_vecs[i].idx, v);
            check(a1_vecs[i].name, v, a1_vecs[i].exp);
        end
        check_all_slots(KEY_A1, "a1");

        // Second key_load 4 cycles into the expansion is ignored.
        @(negedge clk);
        check("ign_ready_before", {127'h0, key_ready}, 128'h1);
        launch(KEY_A1);
        track(KEY_A1, 4, "ign");
        read_slot(4'd10, v);
        check("ign_rd10", v, A1_R10);
        check_all_slots(KEY_A1, "ign");

        // Re-key from DONE.
        @(negedge clk);
        check("rekey_ready_before", {127'h0, key_ready}, 128'h1);
        launch(KEY_SEQ);
        track(KEY_SEQ, 0, "rekey");
        read_slot(4'd10, v);
        check("rekey_rd10", v, SEQ_R10);
        check_all_slots(KEY_SEQ, "rekey");

        // Reset asserted at cycle 5 of an expansion.
        @(negedge clk);
        launch(KEY_A1);
        repeat (5) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("midrst_busy", {127'h0, busy}, 128'h0);
        check("midrst_ready", {127'h0, key_ready}, 128'h0);
        for (int i = 0; i < 16; i++) begin
            read_slot(4'(i), v);
            check($sformatf("midrst_rd%0d", i), v, 128'h0);
        end
        @(negedge clk);
        check("midrst_ready_hold", {127'h0, key_ready}, 128'h0);

        // Load on the first edge after release, all-zero key.
        n_rst = 1'b1;
        launch(128'h0);
        track(128'h0, 0, "zero");
        read_slot(4'd1, v);
        check("zero_rd1_fixed", v, ZERO_R1);
        check_all_slots(128'h0, "zero");

        // All-ones key.
        @(negedge clk);
        launch({128{1'b1}});
        track({128{1'b1}}, 0, "ones");
        check_all_slots({128{1'b1}}, "ones");

        // Out-of-range reads in DONE.
        read_slot(4'd11, v);
        check("done_rd11", v, 128'h0);
        read_slot(4'd15, v);
        check("done_rd15", v, 128'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
